decode_ibuff_compact_latch: RTL

//  Pipeline latch between Decode and the instruction buffer. Receives 2*FETCH_WIDTH decoded

---
 rtl/decode_ibuff_compact_latch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/decode_ibuff_compact_latch.sv
// Decode -> instruction-buffer latch: compacts fissioned slots into low lanes, two-entry skid queue.
// Optional perf counters are enabled with `define FISSION_PERF_EN.
module decode_ibuff_compact_latch #(
  parameter int FETCH_WIDTH = 4,
  parameter int PKT_W       = 96,
  parameter int CNT_W       = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush_i,
  input  logic                               decodeReady_i,
  input  logic [2*FETCH_WIDTH*PKT_W-1:0]     pkt_i,
  input  logic [2*FETCH_WIDTH-1:0]           pktValid_i,
  input  logic                               ibuffFull_i,
  input  logic                               stallFetch_i,
  output logic                               decodeStall_o,
  output logic                               outValid_o,
  output logic [2*FETCH_WIDTH*PKT_W-1:0]     pkt_o,
  output logic [2*FETCH_WIDTH-1:0]           pktValid_o,
  output logic [CNT_W-1:0]                   count_o
`ifdef FISSION_PERF_EN
  ,
  output logic [31:0]                        perfFissionCnt_o,
  output logic [31:0]                        perfStallCyc_o,
  output logic [31:0]                        perfGapCnt_o
`endif
);

  localparam int NS = 2 * FETCH_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               state;
  logic [NS*PKT_W-1:0]  comp_data;
  logic [CNT_W-1:0]     comp_cnt;
  logic [NS*PKT_W-1:0]  skid_data;
  logic [CNT_W-1:0]     skid_cnt;
  logic                 accept;
  logic                 deliver;

  function automatic logic [NS-1:0] therm(input logic [CNT_W-1:0] c);
    logic [NS-1:0] t;
    t = '0;
    for (int i = 0; i < NS; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  // Gather valid slots into ascending low lanes; unused lanes stay zero.
  always_comb begin
    comp_data = '0;
    comp_cnt  = '0;
    for (int s = 0; s < NS; s++) begin
      if (pktValid_i[s]) begin
        comp_data[int'(comp_cnt)*PKT_W +: PKT_W] = pkt_i[s*PKT_W +: PKT_W];
        comp_cnt = comp_cnt + CNT_W'(1);
      end else begin
        comp_cnt = comp_cnt;
      end
    end
  end

  assign accept  = decodeReady_i & ~decodeStall_o & (comp_cnt != '0);
  assign deliver = outValid_o & ~ibuffFull_i & ~stallFetch_i;

  // Queue control; HEAD registers are the outputs themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_EMPTY;
      outValid_o    <= 1'b0;
      decodeStall_o <= 1'b0;
      pkt_o         <= '0;
      pktValid_o    <= '0;
      count_o       <= '0;
      skid_data     <= '0;
      skid_cnt      <= '0;
    end else if (flush_i) begin
      state         <= ST_EMPTY;
      outValid_o    <= 1'b0;
      decodeStall_o <= 1'b0;
      pkt_o         <= '0;
      pktValid_o    <= '0;
      count_o       <= '0;
      skid_data     <= '0;
      skid_cnt      <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state      <= ST_ONE;
            outValid_o <= 1'b1;
            pkt_o      <= comp_data;
            count_o    <= comp_cnt;
            pktValid_o <= therm(comp_cnt);
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            pkt_o      <= comp_data;
            count_o    <= comp_cnt;
            pktValid_o <= therm(comp_cnt);
          end else if (accept) begin
            state         <= ST_TWO;
            decodeStall_o <= 1'b1;
            skid_data     <= comp_data;
            skid_cnt      <= comp_cnt;
          end else if (deliver) begin
            state      <= ST_EMPTY;
            outValid_o <= 1'b0;
            pkt_o      <= '0;
            count_o    <= '0;
            pktValid_o <= '0;
          end
        end
        ST_TWO: begin
          // Decode is stalled here, so only the drain path can fire.
          if (deliver) begin
            state         <= ST_ONE;
            decodeStall_o <= 1'b0;
            pkt_o         <= skid_data;
            count_o       <= skid_cnt;
            pktValid_o    <= therm(skid_cnt);
          end
        end
        default: begin
          state         <= ST_EMPTY;
          outValid_o    <= 1'b0;
          decodeStall_o <= 1'b0;
          pkt_o         <= '0;
          pktValid_o    <= '0;
          count_o       <= '0;
        end
      endcase
    end
  end

`ifdef FISSION_PERF_EN
  logic acc_taken;
  logic has_gap;
  logic [NS:0] valid_ext;

  assign acc_taken = accept & ~flush_i;
  assign valid_ext = {1'b0, pktValid_i};
  assign has_gap   = |(valid_ext & (valid_ext + {{NS{1'b0}}, 1'b1}));

  // Saturating counters; flush intentionally does not clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfFissionCnt_o <= 32'd0;
      perfStallCyc_o   <= 32'd0;
      perfGapCnt_o     <= 32'd0;
    end else begin
      if (acc_taken && (int'(comp_cnt) > FETCH_WIDTH) && (perfFissionCnt_o != 32'hFFFF_FFFF))
        perfFissionCnt_o <= perfFissionCnt_o + 32'd1;
      if (decodeStall_o && (perfStallCyc_o != 32'hFFFF_FFFF))
        perfStallCyc_o <= perfStallCyc_o + 32'd1;
      if (acc_taken && has_gap && (perfGapCnt_o != 32'hFFFF_FFFF))
        perfGapCnt_o <= perfGapCnt_o + 32'd1;
    end
  end
`endif

endmodule
